// File: rtl/toy_tpu_pkg.sv
// Shared defaults, row vector type and column slice helper for the toy TPU datapath.
package toy_tpu_pkg;

    localparam int unsigned DW_DEF   = 32;
    localparam int unsigned COLS_DEF = 4;

    typedef logic [COLS_DEF-1:0][DW_DEF-1:0] row_t;

    // LSB position of column c inside a packed row vector
    function automatic int unsigned col_lo(input int unsigned c, input int unsigned dw);
        return c * dw;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/full/empty/count; head output is zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign do_pop  = i_pop && !o_empty;
    // A pop frees the head slot in the same edge, so a full FIFO still accepts a push
    assign do_push = i_push && (!o_full || do_pop);
    assign o_data  = o_empty ? '0 : mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   o_count <= o_count + 1'b1;
                2'b01:   o_count <= o_count - 1'b1;
                default: o_count <= o_count;
            endcase
        end
    end

endmodule

// File: rtl/mac_result_collector.sv
// Deskews per-column MAC results into aligned rows and buffers them for the writer.
// Optional COLLECTOR_RELU_EN clamps negative column values to zero at FIFO write.
module mac_result_collector
    import toy_tpu_pkg::*;
#(
    parameter int unsigned COLS  = COLS_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_row_valid,
    input  logic [COLS*DW-1:0]         i_col_result,
    output logic                       o_row_valid,
    input  logic                       i_row_ready,
    output logic [COLS*DW-1:0]         o_row_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);

    localparam int unsigned CW = COLS * DW;

    logic [CW-1:0]   aligned;
    logic [CW-1:0]   wr_row;
    logic [COLS-2:0] vld_sr;
    logic            row_done;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    // Column c lags column 0 by c cycles, so it needs COLS-1-c delay stages to line up
    for (genvar c = 0; c < COLS - 1; c++) begin : g_skew
        localparam int unsigned D = COLS - 1 - c;
        logic [DW-1:0] sr [D];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int unsigned k = 0; k < D; k++) sr[k] <= '0;
            end else begin
                sr[0] <= i_col_result[col_lo(c, DW) +: DW];
                for (int unsigned k = 1; k < D; k++) sr[k] <= sr[k-1];
            end
        end

        assign aligned[col_lo(c, DW) +: DW] = sr[D-1];
    end

    assign aligned[col_lo(COLS-1, DW) +: DW] = i_col_result[col_lo(COLS-1, DW) +: DW];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= i_row_valid;
            for (int unsigned k = 1; k < COLS - 1; k++) vld_sr[k] <= vld_sr[k-1];
        end
    end

    assign row_done = vld_sr[COLS-2];

    always_comb begin
        wr_row = aligned;
`ifdef COLLECTOR_RELU_EN
        for (int unsigned c = 0; c < COLS; c++) begin
            if (aligned[col_lo(c, DW) + DW - 1]) wr_row[col_lo(c, DW) +: DW] = '0;
        end
`endif
    end

    assign o_row_valid = !fifo_empty;
    assign pop         = o_row_valid && i_row_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else if (row_done && fifo_full && !pop) begin
            o_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (row_done),
        .i_pop   (pop),
        .i_data  (wr_row),
        .o_data  (o_row_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (o_count)
    );

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector: skewed column stimulus, hand-computed rows.
module tb_mac_result_collector;

    localparam int COLS  = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = COLS * DW;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_row_valid;
    logic [CW-1:0] i_col_result;
    logic          o_row_valid;
    logic          i_row_ready;
    logic [CW-1:0] o_row_data;
    logic [2:0]    o_count;
    logic          o_overflow;

    mac_result_collector #(
        .COLS  (COLS),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_row_valid  (i_row_valid),
        .i_col_result (i_col_result),
        .o_row_valid  (o_row_valid),
        .i_row_ready  (i_row_ready),
        .o_row_data   (o_row_data),
        .o_count      (o_count),
        .o_overflow   (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    int            row_start [$];
    logic [CW-1:0] row_pk    [$];
    logic [CW-1:0] exp_q     [$];

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [CW-1:0] mk_row(input int a, input int b, input int c, input int d);
        return {d, c, b, a};
    endfunction

    // Column c of a row starting at cycle s is presented at cycle s+c
    task automatic drive_cycle();
        logic [CW-1:0] v;
        logic          rv;
        logic [CW-1:0] r;
        v  = '0;
        rv = 1'b0;
        for (int i = 0; i < row_start.size(); i++) begin
            r = row_pk[i];
            if (row_start[i] == cyc) rv = 1'b1;
            for (int c = 0; c < COLS; c++)
                if (row_start[i] + c == cyc) v[c*DW +: DW] = r[c*DW +: DW];
        end
        i_col_result = v;
        i_row_valid  = rv;
    endtask

    task automatic next();
        @(negedge i_clk);
        cyc++;
        drive_cycle();
    endtask

    task automatic add_row(input int start, input logic [CW-1:0] r);
        row_start.push_back(start);
        row_pk.push_back(r);
        drive_cycle();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        next();
        i_rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cyc,
                         output int n, output int first, output int last);
        n = 0; first = -1; last = -1;
        i_row_ready = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (o_row_valid) begin
                if (exp_q.size() > 0) check(tag, o_row_data, exp_q.pop_front());
                n++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            next();
        end
        i_row_ready = 1'b0;
    endtask

    initial begin
        int t, n, first, last;
        logic seen;
        i_rst = 1'b1; i_row_ready = 1'b0; i_row_valid = 1'b0; i_col_result = '0;
        next(); next();
        check("rst_valid", o_row_valid, 0);
        check("rst_count", o_count, 0);
        check("rst_ovf",   o_overflow, 0);
        check("rst_data",  o_row_data, 0);
        i_rst = 1'b0;
        next();

        // single row, latency COLS
        t = cyc;
        add_row(t, mk_row(1, 2, 3, 4));
        next(); next(); next();
        check("single_early", o_row_valid, 0);
        next();
        check("single_valid", o_row_valid, 1);
        check("single_data",  o_row_data, mk_row(1, 2, 3, 4));
        check("single_count", o_count, 1);
        i_row_ready = 1'b1;
        next();
        i_row_ready = 1'b0;
        check("single_pop_count", o_count, 0);
        check("single_pop_valid", o_row_valid, 0);

        // back-to-back rows, pointers wrap twice
        t = cyc;
        for (int k = 0; k < 8; k++) begin
            add_row(t + k, mk_row(10*k, 10*k+1, 10*k+2, 10*k+3));
            exp_q.push_back(mk_row(10*k, 10*k+1, 10*k+2, 10*k+3));
        end
        drain("b2b_row", 20, n, first, last);
        check("b2b_n",     n, 8);
        check("b2b_first", first, t + 4);
        check("b2b_span",  last - first, 7);
        check("b2b_ovf",   o_overflow, 0);
        exp_q.delete();

        // overflow: fifth row dropped
        do_reset();
        t = cyc;
        for (int k = 0; k < 5; k++) add_row(t + k, mk_row(100+10*k, 101+10*k, 102+10*k, 103+10*k));
        for (int i = 0; i < 10; i++) next();
        check("ovf_count", o_count, 4);
        check("ovf_flag",  o_overflow, 1);
        check("ovf_head",  o_row_data, mk_row(100, 101, 102, 103));
        next();
        check("ovf_hold",  o_row_data, mk_row(100, 101, 102, 103));
        for (int k = 0; k < 4; k++) exp_q.push_back(mk_row(100+10*k, 101+10*k, 102+10*k, 103+10*k));
        drain("ovf_drain", 12, n, first, last);
        check("ovf_drain_n",     n, 4);
        check("ovf_drain_count", o_count, 0);
        check("ovf_sticky",      o_overflow, 1);
        exp_q.delete();

        // full with simultaneous push and pop
        do_reset();
        check("full_rst_ovf", o_overflow, 0);
        t = cyc;
        for (int k = 0; k < 4; k++) add_row(t + k, mk_row(200+10*k, 201+10*k, 202+10*k, 203+10*k));
        add_row(t + 5, mk_row(240, 241, 242, 243));
        for (int i = 0; i < 8; i++) next();
        check("full_pre_count", o_count, 4);
        check("full_pre_head",  o_row_data, mk_row(200, 201, 202, 203));
        i_row_ready = 1'b1;
        next();
        i_row_ready = 1'b0;
        check("full_pp_count", o_count, 4);
        check("full_pp_ovf",   o_overflow, 0);
        for (int k = 1; k < 5; k++) exp_q.push_back(mk_row(200+10*k, 201+10*k, 202+10*k, 203+10*k));
        drain("full_drain", 12, n, first, last);
        check("full_drain_n", n, 4);
        exp_q.delete();

        // reset with 2 rows buffered and 2 in flight
        do_reset();
        t = cyc;
        for (int k = 0; k < 4; k++) add_row(t + k, mk_row(300+10*k, 301+10*k, 302+10*k, 303+10*k));
        for (int i = 0; i < 5; i++) next();
        check("mid_pre_count", o_count, 2);
        do_reset();
        check("mid_count", o_count, 0);
        check("mid_valid", o_row_valid, 0);
        check("mid_data",  o_row_data, 0);
        check("mid_ovf",   o_overflow, 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            next();
            seen = seen | o_row_valid;
        end
        check("mid_quiet", seen, 0);

        // negative column values
        t = cyc;
        add_row(t, mk_row(-5, 7, -1, 0));
        for (int i = 0; i < 4; i++) next();
        check("relu_valid", o_row_valid, 1);
`ifdef COLLECTOR_RELU_EN
        check("relu_data", o_row_data, mk_row(0, 7, 0, 0));
`else
        check("relu_data", o_row_data, mk_row(-5, 7, -1, 0));
`endif
        i_row_ready = 1'b1;
        next();
        i_row_ready = 1'b0;
        check("relu_pop_count", o_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mac_result_collector.md
# mac_result_collector

Output end of the systolic MAC array. Captures the per-column results leaving the bottom row of `mac` PEs, which arrive one cycle later per column. Deskews them into one aligned row vector and buffers complete rows in a small FIFO. Hands rows to the downstream writer over a valid/ready handshake.

## Interface
Parameters:
- COLS, 4, number of array columns (≥2)
- DW, 32, result width per column (two's complement)
- DEPTH, 4, FIFO depth in rows (power of 2, ≥2)

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_row_valid  in  1  column 0 of the array presents a valid row result this cycle
- i_col_result  in  COLS*DW  bottom-row `o_result` of each column; column c in bits [c*DW +: DW]
- o_row_valid  out  1  FIFO head row available
- i_row_ready  in  1  downstream accepts head row
- o_row_data  out  COLS*DW  head row, deskewed, same column packing
- o_count  out  $clog2(DEPTH)+1  rows currently buffered
- o_overflow  out  1  sticky: a completed row was dropped because the FIFO was full

## Operation
- Deskew: column c is delayed by (COLS-1-c) registers. Column COLS-1 is used directly. All columns of a row align in the cycle when column COLS-1 presents that row.
- Valid tag: i_row_valid passes through a COLS-1 stage shift register. Its output marks the aligned cycle as "row complete".
- Rows may arrive back-to-back, one per cycle. The pipeline holds up to COLS-1 rows in flight. There is no backpressure into the array.
- Row complete: the aligned vector is written to the FIFO tail.
  - If the FIFO is full and no pop happens that cycle, the row is dropped, o_overflow is set, and FIFO contents are unchanged.
  - A push and a pop in the same cycle while full both succeed, and o_count is unchanged.
- Pop: occurs when o_row_valid && i_row_ready. o_row_data must hold stable while o_row_valid=1 and i_row_ready=0.
- o_count is incremented on push only, decremented on pop only, and unchanged on both or neither.
- Pointers wrap modulo DEPTH.
- o_overflow is cleared only by i_rst.
- Reset (any cycle, including mid-stream): clears the deskew registers, valid tags, pointers, o_count and o_overflow. In-flight rows are discarded and no partial row is ever emitted. Outputs after reset: o_row_valid=0, o_count=0, o_overflow=0, o_row_data=0.

## Timing
- i_row_valid at cycle t (column 0 data at t) means column c data is sampled at t+c. The row is written at the edge ending cycle t+COLS-1.
- With an empty FIFO, o_row_valid=1 from cycle t+COLS, giving a latency of COLS cycles.
- Sustained throughput is 1 row/cycle when i_row_ready is held high.
- FIFO output is registered (no combinational path from i_row_valid or i_col_result to outputs). i_row_ready affects only pointer and count state, not o_row_data in the same cycle.

## Configuration
- COLLECTOR_RELU_EN defined: each column value is clamped to 0 when negative (sign bit set) at FIFO write. The clamp is applied after deskew, so there is no added latency.
- COLLECTOR_RELU_EN undefined: values are stored unmodified.
- This setting does not affect the deskew, handshake or overflow behaviour.

## Structure
- Shared package `toy_tpu_pkg` holds:
  - DW default and COLS default
  - the row vector typedef `row_t` (COLS x DW)
  - the helper for column slice offsets
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/full/empty/count) is instantiated once with width COLS*DW. The deskew and overflow logic stay in the top module.

## Test plan
Default parameters unless stated.
- Single row: i_row_valid at t, columns present 1,2,3,4 at t..t+3 respectively → o_row_valid at t+4 with o_row_data = {4,3,2,1} (col0 in the LSBs), o_count=1. Then pop → o_count=0 and o_row_valid=0.
- Back-to-back: 8 rows, row k with column value 10k+c, i_row_ready=1 → 8 rows out in consecutive cycles, in order, all correct, o_overflow=0.
- Full/overflow: i_row_ready=0, 5 rows sent → o_count=4, o_overflow=1, FIFO holds rows 0..3. Draining returns rows 0..3 exactly.
- Full with simultaneous pop: FIFO holds 4 rows and a row completes in the same cycle as a pop → o_count stays 4, o_overflow=0, and the new row appears last.
- Reset mid-stream: i_rst asserted for 1 cycle while 2 rows are in flight and 2 are buffered → o_count=0, o_row_valid=0, and no row appears in the following 8 cycles without new i_row_valid.
- ReLU: column values {-5, 7, -1, 0} → {0,7,0,0} with COLLECTOR_RELU_EN defined, {-5,7,-1,0} without it.
